// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner for the MIPS EX stage: sequences a shift-add multiplier and a
// restoring divider. Each takes WIDTH iterations plus one sign-fixup cycle.
module hilo_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_abort,
  input  logic             i_read_hilo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int unsigned      PW       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_done_nxt;
  logic               w_dbz_nxt;

  logic               w_signed_in;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic               w_r_signed;
  logic               w_sign_diff;
  logic [PW-1:0]      w_prod;
  logic [PW-1:0]      w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Issue-side operand conditioning: MULT and DIV (op[0]==0) are signed.
  assign w_signed_in = ~i_op[0];
  assign w_div_zero  = i_op[1] & (i_b == '0);
  assign w_a_mag     = (w_signed_in && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag     = (w_signed_in && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

  // One iteration: {acc,q} is the product register for multiply and
  // {remainder,dividend/quotient} for divide.
  assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
  assign w_div_shift = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_m};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  assign w_r_signed  = ~r_op[0];
  assign w_sign_diff = r_sign_a ^ r_sign_b;
  assign w_prod      = {r_acc, r_q};

  always_comb begin
    w_prod_fix = w_prod;
    w_fix_hi   = w_prod[PW-1:WIDTH];
    w_fix_lo   = w_prod[WIDTH-1:0];
    if (w_r_signed && w_sign_diff) begin
      w_prod_fix = ~w_prod + PW'(1);
    end
    if (r_op[1]) begin
      w_fix_lo = (w_r_signed && w_sign_diff) ? (~r_q + WIDTH'(1)) : r_q;
      w_fix_hi = (w_r_signed && r_sign_a) ? (~r_acc + WIDTH'(1)) : r_acc;
    end else begin
      w_fix_hi = w_prod_fix[PW-1:WIDTH];
      w_fix_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start && !i_abort && !w_div_zero) w_state_nxt = S_RUN;
      S_RUN:   if (i_abort)                            w_state_nxt = S_IDLE;
               else if (r_cnt == CNT_LAST)             w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_fix      = 1'b0;
    w_done_nxt = 1'b0;
    w_dbz_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          if (w_div_zero) begin
            w_done_nxt = 1'b1;
            w_dbz_nxt  = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_RUN:   w_step = ~i_abort;
      S_FIXUP: begin
        w_fix      = ~i_abort;
        w_done_nxt = ~i_abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_done_nxt;
      r_dbz  <= w_dbz_nxt;
      if (w_load) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_m      <= i_op[1] ? w_b_mag : w_a_mag;
        r_q      <= i_op[1] ? w_a_mag : w_b_mag;
        r_sign_a <= i_a[WIDTH-1];
        r_sign_b <= i_b[WIDTH-1];
        r_op     <= i_op;
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_op[1]) begin
          r_acc <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_div_ok};
        end else begin
          r_acc <= w_mul_sum[WIDTH:1];
          r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
      end
      if (w_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_stall       = r_busy & (i_start | i_read_hilo);

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle controller that sequences an iterative shift-add multiplier and a restoring divider, and owns the HI/LO register pair of the MIPS datapath.
- Sits beside the ALU in EX: accepts MULT/MULTU/DIV/DIVU issue, raises a stall to the pipeline while busy, and writes HI/LO on completion.
- One operation in flight at a time.

Parameters:
- WIDTH, 32, operand width and width of HI and LO; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  issue request, sampled at the rising edge
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start
- A  input  WIDTH  rs operand (multiplicand / dividend)
- B  input  WIDTH  rt operand (multiplier / divisor)
- Abort  input  1  pipeline flush; cancels the in-flight operation
- ReadHiLo  input  1  MFHI/MFLO in EX this cycle
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register
- Busy  output  1  high in RUN and FIXUP
- Stall  output  1  combinational: Busy & (Start | ReadHiLo)
- Done  output  1  one-cycle completion pulse
- DivByZero  output  1  one-cycle pulse, DIV/DIVU with B == 0

Behaviour:
Reset:
- Rst high forces state IDLE, Hi = 0, Lo = 0, counter = 0, internal operand registers = 0, Busy = 0, Done = 0, DivByZero = 0.
- This holds regardless of the current state, including mid-operation.

States:
- IDLE:
  - Start & !Abort with B != 0 or a multiply op: latch the magnitudes of A and B (absolute value for signed ops, raw value for unsigned), latch both operand signs and Op, clear the counter and the partial accumulator, then go to RUN.
  - DIV/DIVU with B == 0: stay in IDLE, leave Hi/Lo unchanged, and pulse Done and DivByZero in the cycle after the Start edge.
- RUN: performs one shift-add (multiply) or one shift-subtract-restore (divide) step per cycle and increments the counter. After the WIDTH-th step, go to FIXUP.
- FIXUP (one cycle):
  - Signed multiply: negate the 2*WIDTH-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
  - Write Hi = product[2W-1:W] or remainder, and Lo = product[W-1:0] or quotient. Pulse Done and go to IDLE.

Timing:
- With the Start edge as E0, Busy is high after E0 through E33, Hi/Lo update at E33, and Done is high for the cycle following E33.
- Latency is WIDTH+1 cycles from the Start edge to Done.

Arithmetic:
- All arithmetic is modulo width; no overflow flag.
- DIV 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0.
- The magnitude of 0x80000000 is 0x80000000, treated as unsigned.

Boundary cases:
- Start while Busy: ignored and Stall asserted; the pipeline holds the instruction and reissues it when Busy drops.
- Start on the same edge the state returns to IDLE from FIXUP: not accepted; it is accepted on the following edge.
- Abort in RUN/FIXUP: next edge goes to IDLE, Hi/Lo keep their old values, no Done.
- Abort and Start together in IDLE: Abort wins, and there is no DivByZero pulse.
- ReadHiLo while IDLE: no stall; Hi/Lo hold their values.
- Done and DivByZero are never high for two consecutive cycles from a single issue.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy for 33 cycles; Done the cycle after E33; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=5, B=0 with Hi=0x11, Lo=0x22 preloaded from a prior op -> Done and DivByZero high exactly one cycle after Start; Hi/Lo unchanged; Busy never high.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0. DIVU 100/7 -> Lo=14, Hi=2.
- Start held high during RUN plus ReadHiLo pulse -> Stall=1 every busy cycle, second op not started until after Done; Abort asserted at counter=10 -> IDLE next edge, no Done, Hi/Lo retain prior values.
- Rst asserted asynchronously mid-RUN (between clock edges) -> Busy, Done, Hi, Lo all 0 immediately. After release, a fresh MULTU 3*4 -> Lo=12, Hi=0 after 33 cycles.
